// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - state encoding, frame length limits and default timing constants for eth_tx_arb
// Ports: none (package). Provides eth_state_t, ETH_MIN_LEN, ETH_MAX_LEN,
// the NLP/IPG/watchdog default tick counts and the eth_clamp_len helper.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_IPG   = 2'd3
    } eth_state_t;

    localparam logic [10:0] ETH_MIN_LEN = 11'd60;
    localparam logic [10:0] ETH_MAX_LEN = 11'd1514;

    localparam int ETH_NLP_PERIOD_DEF = 160000;
    localparam int ETH_IPG_TICKS_DEF  = 96;
    localparam int ETH_WDOG_TICKS_DEF = 16384;

    // Runts are padded up to the minimum frame, oversize requests are cut to the maximum.
    function automatic logic [10:0] eth_clamp_len(input logic [10:0] len);
        if (len < ETH_MIN_LEN) begin
            return ETH_MIN_LEN;
        end else if (len > ETH_MAX_LEN) begin
            return ETH_MAX_LEN;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - combinational 4-way round-robin winner selection
// Ports:
//   req      in  4  request flags
//   last_sel in  2  index of the previous winner; scanning starts at last_sel+1
//   valid    out 1  at least one request is set
//   idx      out 2  index of the winning requester (last_sel when valid=0)
module eth_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last_sel,
    output logic       valid,
    output logic [1:0] idx
);

    // Walk the offsets from farthest to nearest so the nearest set bit after
    // last_sel is the one that remains assigned at the end of the loop.
    always_comb begin
        valid = |req;
        idx   = last_sel;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_sel + 2'(k)]) begin
                idx = last_sel + 2'(k);
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - 10BASE-T transmit arbiter: round-robin frame grant, inter-packet gap and link pulses
// Optional feature macro: ETH_TX_ARB_WDOG_EN enables the WAIT-state watchdog (abort/err).
// Ports:
//   clk        in  1   system clock
//   rst        in  1   asynchronous active-high reset
//   clk_en     in  1   bit-rate tick; all state advances only when set
//   req        in  4   per-requester frame-ready flags
//   req_len    in  44  four 11-bit frame lengths, requester i at [11i+10:11i]
//   grant      out 4   one-hot transmitter owner, or zero
//   tx_start   out 1   one-tick start pulse to the transmitter
//   tx_len     out 11  clamped length of the granted frame
//   tx_sel     out 2   index of the granted requester
//   tx_done    in  1   transmitter end-of-frame pulse
//   link_pulse out 1   one-tick normal link pulse request
//   abort      out 1   one-tick watchdog abort
//   err        out 1   sticky watchdog error
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int NLP_PERIOD = ETH_NLP_PERIOD_DEF,
    parameter int IPG_TICKS  = ETH_IPG_TICKS_DEF,
    parameter int WDOG_TICKS = ETH_WDOG_TICKS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [3:0]  req,
    input  logic [43:0] req_len,
    output logic [3:0]  grant,
    output logic        tx_start,
    output logic [10:0] tx_len,
    output logic [1:0]  tx_sel,
    input  logic        tx_done,
    output logic        link_pulse,
    output logic        abort,
    output logic        err
);

    localparam logic [31:0] NLP_LAST = 32'(NLP_PERIOD - 1);
    localparam logic [31:0] IPG_LAST = 32'(IPG_TICKS - 1);

    eth_state_t  state_q;
    eth_state_t  state_d;
    logic [1:0]  last_sel_q;
    logic [31:0] nlp_cnt_q;
    logic [31:0] ipg_cnt_q;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [10:0] pick_len;

    logic        nlp_hit;
    logic        arb_go;
    logic        ipg_end;
    logic        wdog_hit;

    eth_rr_pick u_pick (
        .req      (req),
        .last_sel (last_sel_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        pick_len = '0;
        for (int i = 0; i < 4; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_len = req_len[11*i +: 11];
            end
        end
    end

    // The NLP counter saturates at NLP_LAST outside IDLE, so an expiry during a
    // frame surfaces as a pulse on the first IDLE tick. The pulse is decoded from
    // the counter, occupying the NLP_PERIOD-th tick; the tick it occupies is the
    // one on which arbitration is suppressed.
    assign nlp_hit    = (state_q == ST_IDLE) && (nlp_cnt_q == NLP_LAST);
    assign link_pulse = nlp_hit;
    assign arb_go     = (state_q == ST_IDLE) && !nlp_hit && pick_valid;
    assign ipg_end    = (state_q == ST_IPG) && (ipg_cnt_q == IPG_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (arb_go) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (tx_done || wdog_hit) state_d = ST_IPG;
            ST_IPG:   if (ipg_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_sel_q <= 2'd3;
            nlp_cnt_q  <= '0;
            ipg_cnt_q  <= '0;
            grant      <= '0;
            tx_start   <= 1'b0;
            tx_len     <= '0;
            tx_sel     <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            tx_start <= (state_q == ST_START);

            if (arb_go) begin
                grant  <= 4'b0001 << pick_idx;
                tx_sel <= pick_idx;
                tx_len <= eth_clamp_len(pick_len);
            end else if ((state_q == ST_WAIT) && (state_d == ST_IPG)) begin
                grant <= '0;
            end

            if (nlp_hit || (state_q == ST_START)) begin
                nlp_cnt_q <= '0;
            end else if (nlp_cnt_q != NLP_LAST) begin
                nlp_cnt_q <= nlp_cnt_q + 32'd1;
            end

            if ((state_q == ST_IPG) && !ipg_end) begin
                ipg_cnt_q <= ipg_cnt_q + 32'd1;
            end else begin
                ipg_cnt_q <= '0;
            end

            if (ipg_end) begin
                last_sel_q <= tx_sel;
            end
        end
    end

`ifdef ETH_TX_ARB_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_TICKS - 1);

    logic [31:0] wdog_cnt_q;

    // Fires on the WDOG_TICKS-th WAIT tick unless tx_done arrives on that same tick.
    assign wdog_hit = (state_q == ST_WAIT) && !tx_done && (wdog_cnt_q == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            abort      <= 1'b0;
            err        <= 1'b0;
        end else if (clk_en) begin
            if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
                wdog_cnt_q <= wdog_cnt_q + 32'd1;
            end else begin
                wdog_cnt_q <= '0;
            end
            abort <= wdog_hit;
            if (wdog_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign abort    = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - self-checking bench for eth_tx_arb with a round-robin/clamp reference model
module tb_eth_tx_arb;

    localparam int NLP  = 100;
    localparam int IPG  = 8;
    localparam int WDOG = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [3:0]  req;
    logic [43:0] req_len;
    logic [3:0]  grant;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [1:0]  tx_sel;
    logic        tx_done;
    logic        link_pulse;
    logic        abort;
    logic        err;

    int total = 0;
    int bad = 0;
    int gap_max = 0;

    always #5 clk = ~clk;

    eth_tx_arb #(.NLP_PERIOD(NLP), .IPG_TICKS(IPG), .WDOG_TICKS(WDOG)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .req_len(req_len),
        .grant(grant), .tx_start(tx_start), .tx_len(tx_len), .tx_sel(tx_sel),
        .tx_done(tx_done), .link_pulse(link_pulse), .abort(abort), .err(err)
    );

    // Reference: first set request scanning upward from last+1, wrapping at 4.
    function automatic int model_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int model_clamp(input int len);
        if (len < 60) return 60;
        if (len > 1514) return 1514;
        return len;
    endfunction

    // One clk_en tick, optionally preceded by a few gated clocks.
    task automatic do_tick();
        int n;
        n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (n) begin
            clk_en = 1'b0;
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
        clk_en = 1'b0;
    endtask

    task automatic do_reset();
        clk_en = 1'b0; req = '0; req_len = '0; tx_done = 1'b0; gap_max = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            do_tick();
            if (tx_start === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; req = 4'hF; req_len = {4{11'd700}}; tx_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (tx_len !== 11'd0) begin bad++; $display("FAIL reset_tx_len: got %0d want 0", tx_len); end
        total++; if (tx_sel !== 2'd0) begin bad++; $display("FAIL reset_tx_sel: got %0d want 0", tx_sel); end
        total++; if (link_pulse !== 1'b0) begin bad++; $display("FAIL reset_link_pulse: got %b want 0", link_pulse); end
        total++; if ({abort, err} !== 2'b00) begin bad++; $display("FAIL reset_abort_err: got %b want 00", {abort, err}); end
        rst = 1'b0; clk_en = 1'b0; req = '0; tx_done = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; req_len = {33'd0, 11'd100};
        do_tick();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant_t1: got %b want 0001", grant); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_t1: got %b want 0", tx_start); end
        do_tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_t2: got %b want 1", tx_start); end
        total++; if (tx_len !== 11'd100) begin bad++; $display("FAIL single_len: got %0d want 100", tx_len); end
        total++; if (tx_sel !== 2'd0) begin bad++; $display("FAIL single_sel: got %0d want 0", tx_sel); end
        do_tick();
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_t3: got %b want 0", tx_start); end
        req = '0;
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL single_grant_ipg: got %b want 0000", grant); end
        repeat (IPG) do_tick();
    endtask

    task automatic test_clamp();
        int lens [8] = '{10, 2000, 59, 60, 1514, 1515, 0, 2047};
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_len = {12'($urandom), $urandom};
            req_len[22 +: 11] = 11'(lens[i]);
            req = 4'b0100;
            wait_start(lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL clamp_latency[%0d]: got %0d want 2", i, lat); end
            total++; if (tx_len !== 11'(model_clamp(lens[i]))) begin bad++; $display("FAIL clamp_len[%0d]: got %0d want %0d", i, tx_len, model_clamp(lens[i])); end
            req = '0;
            tx_done = 1'b1; do_tick(); tx_done = 1'b0;
            repeat (IPG) do_tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int lat;
        do_reset();
        req = 4'hF; req_len = {12'($urandom), $urandom};
        for (int i = 0; i < 5; i++) begin
            wait_start(lat);
            if (i == 0) begin
                total++; if (lat !== 2) begin bad++; $display("FAIL rr_first_latency: got %0d want 2", lat); end
            end else begin
                total++; if (lat < IPG + 2) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want >= %0d", i, lat, IPG + 2); end
            end
            total++; if (grant !== exp_g[i]) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g[i]); end
            repeat ($urandom_range(5, 1)) do_tick();
            tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        end
        req = '0;
        repeat (IPG) do_tick();
    endtask

    task automatic test_random();
        int last = 3;
        int exp_idx, exp_len, lat, w;
        logic [3:0] r;
        do_reset();
        gap_max = 2;
        for (int f = 0; f < 40; f++) begin
            r = 4'($urandom_range(15, 1));
            req_len = {12'($urandom), $urandom};
            exp_idx = model_pick(r, last);
            exp_len = model_clamp(int'(req_len[11*exp_idx +: 11]));
            req = r;
            wait_start(lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 2", f, lat); end
            total++; if (tx_sel !== 2'(exp_idx)) begin bad++; $display("FAIL rand_sel[%0d]: got %0d want %0d", f, tx_sel, exp_idx); end
            total++; if (grant !== 4'(1 << exp_idx)) begin bad++; $display("FAIL rand_grant[%0d]: got %b want %b", f, grant, 4'(1 << exp_idx)); end
            total++; if (tx_len !== 11'(exp_len)) begin bad++; $display("FAIL rand_len[%0d]: got %0d want %0d", f, tx_len, exp_len); end
            w = int'($urandom_range(20, 1));
            repeat (w) begin
                req = 4'($urandom); req_len = {12'($urandom), $urandom};
                do_tick();
            end
            total++; if ({grant, tx_len} !== {4'(1 << exp_idx), 11'(exp_len)}) begin bad++; $display("FAIL rand_wait_hold[%0d]: got %b/%0d want %b/%0d", f, grant, tx_len, 4'(1 << exp_idx), exp_len); end
            tx_done = 1'b1; do_tick(); tx_done = 1'b0;
            total++; if (grant !== 4'b0) begin bad++; $display("FAIL rand_grant_drop[%0d]: got %b want 0000", f, grant); end
            repeat (IPG) begin
                tx_done = ($urandom_range(3, 0) == 0);
                do_tick();
            end
            tx_done = 1'b0;
            last = exp_idx;
        end
        gap_max = 0;
    endtask

    task automatic test_nlp();
        int first, period, lat;
        do_reset();
        first = -1;
        for (int i = 1; i <= 300; i++) begin
            do_tick();
            if (link_pulse === 1'b1) begin first = i; break; end
        end
        total++; if (first !== NLP - 1) begin bad++; $display("FAIL nlp_first: got %0d want %0d", first, NLP - 1); end
        do_tick();
        total++; if (link_pulse !== 1'b0) begin bad++; $display("FAIL nlp_width: got %b want 0", link_pulse); end
        period = -1;
        for (int i = 2; i <= 300; i++) begin
            do_tick();
            if (link_pulse === 1'b1) begin period = i; break; end
        end
        total++; if (period !== NLP) begin bad++; $display("FAIL nlp_period: got %0d want %0d", period, NLP); end
        req = 4'b0001; req_len = {33'd0, 11'd200};
        do_tick();
        total++; if ({grant, link_pulse} !== 5'b0) begin bad++; $display("FAIL nlp_skip_arb: got %b want 00000", {grant, link_pulse}); end
        wait_start(lat);
        total++; if (lat + 1 !== 3) begin bad++; $display("FAIL nlp_req_latency: got %0d want 3", lat + 1); end
        req = '0;
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        repeat (IPG) do_tick();
    endtask

`ifdef ETH_TX_ARB_WDOG_EN
    task automatic test_wdog();
        int lat, hit;
        do_reset();
        req = 4'b0001; req_len = {33'd0, 11'd300};
        wait_start(lat);
        req = '0;
        hit = -1;
        for (int i = 1; i <= 200; i++) begin
            do_tick();
            if (abort === 1'b1) begin hit = i; break; end
        end
        total++; if (hit !== WDOG) begin bad++; $display("FAIL wdog_abort_tick: got %0d want %0d", hit, WDOG); end
        total++; if ({err, grant} !== 5'b10000) begin bad++; $display("FAIL wdog_err_grant: got %b want 10000", {err, grant}); end
        do_tick();
        total++; if ({abort, err} !== 2'b01) begin bad++; $display("FAIL wdog_abort_width: got %b want 01", {abort, err}); end
        repeat (IPG) do_tick();
        req = 4'b0010;
        wait_start(lat);
        req = '0;
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL wdog_err_sticky: got %b want 1", err); end
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wdog_err_reset: got %b want 0", err); end
    endtask
`else
    task automatic test_deferred_nlp();
        int lat;
        bit bad_hold = 1'b0;
        do_reset();
        req = 4'b0001; req_len = {33'd0, 11'd64};
        wait_start(lat);
        req = '0;
        repeat (150) begin
            do_tick();
            if (link_pulse !== 1'b0 || abort !== 1'b0 || err !== 1'b0 || grant !== 4'b0001) bad_hold = 1'b1;
        end
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        repeat (IPG) begin
            if (link_pulse !== 1'b0) bad_hold = 1'b1;
            do_tick();
        end
        total++; if (bad_hold) begin bad++; $display("FAIL wait_hold: got bad hold flag want clean wait/ipg"); end
        total++; if (link_pulse !== 1'b1) begin bad++; $display("FAIL nlp_deferred: got %b want 1", link_pulse); end
        do_tick();
        total++; if (link_pulse !== 1'b0) begin bad++; $display("FAIL nlp_deferred_width: got %b want 0", link_pulse); end
    endtask
`endif

    task automatic test_reset_mid();
        int lat;
        bit quiet = 1'b1;
        do_reset();
        req = 4'b1000; req_len = {11'd500, 33'd0};
        wait_start(lat);
        do_tick();
        #2 rst = 1'b1;
        #1;
        total++; if ({grant, tx_start, abort} !== 6'b0) begin bad++; $display("FAIL rst_mid_async: got %b want 000000", {grant, tx_start, abort}); end
        @(negedge clk);
        rst = 1'b0; req = '0;
        repeat (20) begin
            do_tick();
            if (tx_start !== 1'b0 || grant !== 4'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL rst_mid_quiet: got activity want none"); end
        req = 4'b0100;
        wait_start(lat);
        total++; if ({lat, tx_sel} !== {32'd2, 2'd2}) begin bad++; $display("FAIL rst_mid_restart: got lat=%0d sel=%0d want lat=2 sel=2", lat, tx_sel); end
        req = '0;
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        repeat (IPG) do_tick();
    endtask

    task automatic test_clk_en();
        do_reset();
        req = 4'b0010; req_len = {22'd0, 11'd700, 11'd0};
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL done_idle_ignored: got %b want 0010", grant); end
        do_tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL gate_start: got %b want 1", tx_start); end
        clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if ({tx_start, grant, tx_len} !== {1'b1, 4'b0010, 11'd700}) begin bad++; $display("FAIL gate_hold: got %b/%b/%0d want 1/0010/700", tx_start, grant, tx_len); end
        do_tick();
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL gate_start_end: got %b want 0", tx_start); end
        req = '0;
        tx_done = 1'b1; do_tick(); tx_done = 1'b0;
        repeat (IPG) do_tick();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; req = '0; req_len = '0; tx_done = 1'b0;
        test_reset();
        test_single();
        test_clamp();
        test_round_robin();
        test_random();
        test_nlp();
`ifdef ETH_TX_ARB_WDOG_EN
        test_wdog();
`else
        test_deferred_nlp();
`endif
        test_reset_mid();
        test_clk_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
